// File: rtl/i2c_txn_sched_pkg.sv
// i2c_sched_pkg: scheduler states, address width and address-byte builder
package i2c_sched_pkg;
  localparam int ADDR_W = 7;
  typedef enum logic [2:0] {IDLE, START, ADDR, DATA, STOP, DONE} state_t;
  function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] addr, input logic rnw);
    return {addr, rnw};
  endfunction
endpackage

// File: rtl/i2c_txn_sched_if.sv
// i2c_txn_sched_if: engine control bus; master = scheduler (strobes, tx byte, ack level), slave = byte engine (done, ack, rx byte)
interface i2c_txn_sched_if;
  logic eng_start;
  logic eng_stop;
  logic eng_tx_go;
  logic [7:0] eng_tx_byte;
  logic eng_rx_go;
  logic eng_ack_out;
  logic eng_done;
  logic eng_ack_in;
  logic [7:0] eng_rx_byte;
  modport master (
    output eng_start, eng_stop, eng_tx_go, eng_tx_byte, eng_rx_go, eng_ack_out,
    input  eng_done, eng_ack_in, eng_rx_byte
  );
  modport slave (
    input  eng_start, eng_stop, eng_tx_go, eng_tx_byte, eng_rx_go, eng_ack_out,
    output eng_done, eng_ack_in, eng_rx_byte
  );
endinterface

// File: rtl/i2c_rr_arb.sv
// i2c_rr_arb: combinational round-robin picker; req + ptr in, one-hot gnt and its index out (first request at or after ptr)
module i2c_rr_arb #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  always_comb begin
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
    gnt = '0;
    gnt[idx] = |req;
  end
endmodule

// File: rtl/i2c_txn_sched.sv
// i2c_txn_sched: round-robin I2C transaction scheduler; clk/rstn, req/req_addr/req_rnw/req_len/wdata in, grant/wr_take/rd_data/rd_valid/done/nack out, engine strobes on eng; watchdog under I2C_SCHED_TMO_EN
module i2c_txn_sched
  import i2c_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LEN_W = 4
`ifdef I2C_SCHED_TMO_EN
  , parameter int TMO_CYC = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]       req_rnw,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*8-1:0]     wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       wr_take,
  output logic [7:0]            rd_data,
  output logic [NREQ-1:0]       rd_valid,
  output logic [NREQ-1:0]       done,
  output logic                  nack,
  i2c_txn_sched_if.master       eng
);
  localparam int IW = $clog2(NREQ);
  state_t state, state_n;
  logic [IW-1:0] own, rr, pick;
  logic [NREQ-1:0] own_oh, pick_oh;
  logic any, issued, nack_f, rnw_q, wait_st, tx_wait, fire, ev, rd_ev, tmo_hit;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] len_q, cnt;
  i2c_rr_arb #(.NREQ(NREQ)) u_arb (.req(req), .ptr(rr), .gnt(pick_oh), .idx(pick));
  assign any = |req;
  assign wait_st = state inside {START, ADDR, DATA, STOP};
  assign tx_wait = state == ADDR || (state == DATA && !rnw_q);
  assign fire = wait_st && !issued;
  assign ev = wait_st && issued && eng.eng_done;
  assign rd_ev = ev && state == DATA && rnw_q;
`ifdef I2C_SCHED_TMO_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo;
  always_ff @(posedge clk) tmo <= (!rstn || state_n != state) ? '0 : tmo + 1'b1;
  assign tmo_hit = wait_st && issued && !eng.eng_done && tmo == TW'(TMO_CYC - 1);
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any ? START : IDLE;
      START:   state_n = ev ? ADDR : START;
      ADDR:    state_n = !ev ? ADDR : (eng.eng_ack_in || len_q == '0) ? STOP : DATA;
      DATA:    state_n = ev && (cnt == LEN_W'(1) || (!rnw_q && eng.eng_ack_in)) ? STOP : DATA;
      STOP:    state_n = ev ? DONE : STOP;
      default: state_n = IDLE;
    endcase
    if (tmo_hit) state_n = DONE;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      rr <= '0;
      own <= '0;
      own_oh <= '0;
      cnt <= '0;
      issued <= 1'b0;
      nack_f <= 1'b0;
      addr_q <= '0;
      rnw_q <= 1'b0;
      len_q <= '0;
      rd_data <= '0;
      rd_valid <= '0;
    end else begin
      state <= state_n;
      issued <= state_n == state && (fire || (issued && !ev));
      rd_valid <= rd_ev ? own_oh : '0;
      if (rd_ev) rd_data <= eng.eng_rx_byte;
      if (state == IDLE && any) begin
        own <= pick;
        own_oh <= pick_oh;
        addr_q <= req_addr[pick*ADDR_W +: ADDR_W];
        rnw_q <= req_rnw[pick];
        len_q <= req_len[pick*LEN_W +: LEN_W];
        nack_f <= 1'b0;
      end
      if (ev && state == ADDR) cnt <= len_q;
      if (ev && state == DATA) cnt <= cnt - 1'b1;
      if ((ev && tx_wait && eng.eng_ack_in) || tmo_hit) nack_f <= 1'b1;
      if (state == DONE) rr <= own == IW'(NREQ - 1) ? '0 : own + 1'b1;
    end
  end
  assign eng.eng_start = fire && state == START;
  assign eng.eng_stop = (fire && state == STOP) || tmo_hit;
  assign eng.eng_tx_go = fire && tx_wait;
  assign eng.eng_rx_go = fire && state == DATA && rnw_q;
  assign eng.eng_tx_byte = state == ADDR ? addr_byte(addr_q, rnw_q) :
                           (state == DATA && !rnw_q) ? wdata[own*8 +: 8] : 8'h00;
  assign eng.eng_ack_out = !(state == DATA && rnw_q && cnt != LEN_W'(1));
  assign grant = wait_st ? own_oh : '0;
  assign wr_take = (fire && state == DATA && !rnw_q) ? own_oh : '0;
  assign done = state == DONE ? own_oh : '0;
  assign nack = state == DONE && nack_f;
endmodule

// File: tb/tb_i2c_txn_sched.sv
// tb_i2c_txn_sched: randomized self-checking bench comparing i2c_txn_sched against a transaction-level model
module tb_i2c_txn_sched;
  localparam int NREQ = 4;
  localparam int LEN_W = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*7-1:0] req_addr = '0;
  logic [NREQ-1:0] req_rnw = '0;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic [NREQ*8-1:0] wdata = '0;
  logic [NREQ-1:0] grant, wr_take, rd_valid, done;
  logic [7:0] rd_data;
  logic nack;
  i2c_txn_sched_if eng();
  i2c_txn_sched #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_addr(req_addr), .req_rnw(req_rnw),
    .req_len(req_len), .wdata(wdata), .grant(grant), .wr_take(wr_take),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .nack(nack), .eng(eng)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int op_log[$], exp_ops[$], done_log[$];
  logic [7:0] rd_log[$], exp_rd[$], rx_q[$];
  logic nack_log[$], ack_q[$];
  logic [7:0] rxv[16];
  logic [7:0] wbuf[NREQ][16];
  int widx[NREQ];
  int wt_cnt = 0;
  int bad = 0;
  int overlap = 0;
  int rr_m = 0;
  logic [NREQ-1:0] exp_grant = '0;
  logic chk_g = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  initial begin : responder
    int cd;
    logic is_tx, is_rx;
    cd = 0;
    is_tx = 1'b0;
    is_rx = 1'b0;
    eng.eng_done = 1'b0;
    eng.eng_ack_in = 1'b0;
    eng.eng_rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      eng.eng_done = 1'b0;
      if (eng.eng_start || eng.eng_stop || eng.eng_tx_go || eng.eng_rx_go) begin
        if (cd != 0) overlap++;
        if (eng.eng_start) op_log.push_back(32'h100);
        if (eng.eng_stop) op_log.push_back(32'h200);
        if (eng.eng_tx_go) op_log.push_back(32'h300 | eng.eng_tx_byte);
        if (eng.eng_rx_go) op_log.push_back(32'h400 | eng.eng_ack_out);
        is_tx = eng.eng_tx_go;
        is_rx = eng.eng_rx_go;
        cd = $urandom_range(3, 1);
      end else if (cd != 0) begin
        cd--;
        if (cd == 0) begin
          eng.eng_done = 1'b1;
          eng.eng_ack_in = (is_tx && ack_q.size() != 0) ? ack_q.pop_front() : 1'b0;
          eng.eng_rx_byte = (is_rx && rx_q.size() != 0) ? rx_q.pop_front() : 8'h5a;
        end
      end
    end
  end

  initial begin : monitor
    for (int r = 0; r < NREQ; r++) widx[r] = 0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) if (wr_take[r]) begin widx[r]++; wt_cnt++; end
      if (|rd_valid) begin
        rd_log.push_back(rd_data);
        if (chk_g && rd_valid !== exp_grant) bad++;
      end
      for (int r = 0; r < NREQ; r++) if (done[r]) begin done_log.push_back(r); nack_log.push_back(nack); end
      if (grant !== '0 && (!$onehot(grant) || (chk_g && grant !== exp_grant))) bad++;
      if (chk_g && wr_take !== '0 && wr_take !== exp_grant) bad++;
      #2;
      for (int r = 0; r < NREQ; r++) wdata[r*8 +: 8] = wbuf[r][widx[r] % 16];
    end
  end

  task automatic txn(input int o, input logic [6:0] a, input logic rnw, input int len, input int nk);
    bit ok, en;
    int exp_wt;
    exp_ops = {}; exp_rd = {}; ack_q = {}; rx_q = {};
    op_log = {}; rd_log = {}; done_log = {}; nack_log = {}; wt_cnt = 0;
    exp_ops.push_back(32'h100);
    exp_ops.push_back(32'h300 | {a, rnw});
    ack_q.push_back(nk == 0);
    en = (nk == 0);
    for (int i = 0; i < len && !en; i++) begin
      if (rnw) begin
        exp_ops.push_back(32'h400 | (i == len - 1));
        exp_rd.push_back(rxv[i]);
        rx_q.push_back(rxv[i]);
      end else begin
        exp_ops.push_back(32'h300 | wbuf[o][i]);
        ack_q.push_back(nk == i + 1);
        en = (nk == i + 1);
      end
    end
    exp_ops.push_back(32'h200);
    exp_wt = rnw ? 0 : exp_ops.size() - 3;
    widx[o] = 0;
    exp_grant = NREQ'(1) << o;
    chk_g = 1'b1;
    req_addr[o*7 +: 7] = a;
    req_rnw[o] = rnw;
    req_len[o*LEN_W +: LEN_W] = LEN_W'(len);
    req[o] = 1'b1;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (|done) begin ok = 1; req = '0; end
    end
    req = '0;
    repeat (4) @(negedge clk);
    chk_g = 1'b0;
    chk("done_seen", ok, 1);
    chk("op_count", op_log.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < op_log.size(); i++)
      chk($sformatf("op%0d", i), op_log[i], exp_ops[i]);
    chk("rd_count", rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      chk($sformatf("rd%0d", i), rd_log[i], exp_rd[i]);
    chk("wr_take_count", wt_cnt, exp_wt);
    chk("done_count", done_log.size(), 1);
    if (done_log.size() == 1) begin
      chk("done_owner", done_log[0], o);
      chk("nack", nack_log[0], en);
    end
    rr_m = (o + 1) % NREQ;
  endtask

  task automatic multi(input logic [NREQ-1:0] mask, input int n);
    int got[$], want_q[$];
    int p, k;
    ack_q = {}; rx_q = {};
    chk_g = 1'b0;
    p = rr_m;
    for (int t = 0; t < n; t++) begin
      k = p;
      while (!mask[k]) k = (k + 1) % NREQ;
      want_q.push_back(k);
      p = (k + 1) % NREQ;
    end
    for (int r = 0; r < NREQ; r++) if (mask[r]) begin
      req_addr[r*7 +: 7] = 7'(r + 32);
      req_rnw[r] = 1'b0;
      req_len[r*LEN_W +: LEN_W] = LEN_W'(1);
      wbuf[r][0] = 8'(r);
      widx[r] = 0;
    end
    req = mask;
    for (int i = 0; i < 4000 && got.size() < n; i++) begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) if (done[r]) got.push_back(r);
      if (got.size() >= n) req = '0;
    end
    req = '0;
    repeat (4) @(negedge clk);
    chk("arb_count", got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("arb_order%0d", i), got[i], want_q[i]);
    rr_m = p;
  endtask

  initial begin : main
    int o, len, nk, n, stops;
    logic rnw;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_take", wr_take, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_nack", nack, 0);
    chk("rst_strobes", {eng.eng_start, eng.eng_stop, eng.eng_tx_go, eng.eng_rx_go}, 0);
    chk("rst_tx_byte", eng.eng_tx_byte, 0);
    chk("rst_ack_out", eng.eng_ack_out, 1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    wbuf[1][0] = 8'hA5; wbuf[1][1] = 8'h3C;
    txn(1, 7'h50, 1'b0, 2, -1);
    rxv[0] = 8'h11; rxv[1] = 8'h22; rxv[2] = 8'h33;
    txn(0, 7'h48, 1'b1, 3, -1);
    txn(3, 7'h2A, 1'b0, 3, 0);
    txn(2, 7'h10, 1'b1, 0, -1);
    for (int i = 0; i < 4; i++) wbuf[1][i] = 8'(8'hC0 + i);
    txn(1, 7'h77, 1'b0, 4, 2);
    for (int t = 0; t < 16; t++) begin
      o = $urandom_range(NREQ - 1, 0);
      rnw = 1'($urandom_range(1, 0));
      len = $urandom_range(6, 0);
      for (int i = 0; i < 16; i++) begin wbuf[o][i] = 8'($urandom); rxv[i] = 8'($urandom); end
      nk = ($urandom_range(3, 0) == 0) ? (rnw ? 0 : $urandom_range(len, 0)) : -1;
      txn(o, 7'($urandom), rnw, len, nk);
    end
    wbuf[3][0] = 8'h99;
    txn(3, 7'h0F, 1'b0, 1, -1);
    multi(4'b0101, 4);
    op_log = {}; done_log = {}; ack_q = {}; rx_q = {};
    for (int i = 0; i < 16; i++) wbuf[2][i] = 8'($urandom);
    widx[2] = 0;
    req_addr[2*7 +: 7] = 7'h33;
    req_rnw[2] = 1'b0;
    req_len[2*LEN_W +: LEN_W] = LEN_W'(4);
    req[2] = 1'b1;
    n = 0;
    for (int i = 0; i < 3000 && n < 2; i++) begin
      @(negedge clk);
      if (wr_take[2]) n++;
    end
    chk("rst_mid_reached", n, 2);
    @(negedge clk);
    rstn = 1'b0;
    req = '0;
    @(negedge clk);
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_stop", eng.eng_stop, 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    stops = 0;
    foreach (op_log[i]) if (op_log[i] == 32'h200) stops++;
    chk("rst_mid_no_stop", stops, 0);
    chk("rst_mid_no_done", done_log.size(), 0);
    rr_m = 0;
    multi(4'b1001, 2);
    chk("strobe_overlap", overlap, 0);
    chk("owner_signals", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
